mem_stage: RTL and testbench

- Memory-access stage of the RISC-V pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Decodes the registered memory opcode and runs one load or store transaction to the memory controller through a req/ready handshake.
- Sign- or zero-extends load data and forwards the write-back triple (destination register, write enable, data).
- Holds the pipeline through stall_req while a transaction is outstanding.

---
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs one load/store per memory opcode through a
// req/ready handshake, extends load data and presents the write-back triple.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   in_aluop,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [4:0]        in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              mc_ready,
  input  logic [DATA_W-1:0] mc_rdata,
  output logic              mc_req,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  output logic [1:0]        mc_len,
  output logic              stall_req,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata
);

  // state | meaning
  // IDLE  | pass-through for NOP; launches a request on a memory opcode
  // BUSY  | request outstanding, waiting for mc_ready
  // DONE  | transaction finished, write-back presented, pipeline released
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

  state_t            state, state_nx;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] result_q;
  logic              is_mem, is_store;
  logic [1:0]        len;
  logic [DATA_W-1:0] load_ext;

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    len      = 2'd0;
    case (in_aluop)
      OP_LB, OP_LBU: len = 2'd0;
      OP_LH, OP_LHU: len = 2'd1;
      OP_LW:         len = 2'd3;
      OP_SB:         is_store = 1'b1;
      OP_SH: begin
        is_store = 1'b1;
        len      = 2'd1;
      end
      OP_SW: begin
        is_store = 1'b1;
        len      = 2'd3;
      end
      default:       is_mem = 1'b0;
    endcase
  end

  // Extension keys off the opcode latched at launch, not the live input.
  always_comb begin
    load_ext = mc_rdata;
    case (op_q)
      OP_LB:   load_ext = {{(DATA_W-8){mc_rdata[7]}}, mc_rdata[7:0]};
      OP_LBU:  load_ext = {{(DATA_W-8){1'b0}}, mc_rdata[7:0]};
      OP_LH:   load_ext = {{(DATA_W-16){mc_rdata[15]}}, mc_rdata[15:0]};
      OP_LHU:  load_ext = {{(DATA_W-16){1'b0}}, mc_rdata[15:0]};
      default: load_ext = mc_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall_req = 1'b0;
    wb_wd     = in_wd;
    wb_wreg   = in_wreg;
    wb_wdata  = in_wdata;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall_req = 1'b1;
          wb_wreg   = 1'b0;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        wb_wreg   = 1'b0;
        if (mc_ready) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        if (mc_we) wb_wreg  = 1'b0;
        else       wb_wdata = result_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_req   <= 1'b0;
      mc_we    <= 1'b0;
      mc_addr  <= '0;
      mc_wdata <= '0;
      mc_len   <= 2'd0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            mc_req   <= 1'b1;
            mc_we    <= is_store;
            mc_addr  <= in_mem_addr;
            mc_wdata <= in_wdata;
            mc_len   <= len;
            op_q     <= in_aluop;
          end
        end
        BUSY: begin
          if (mc_ready) begin
            mc_req <= 1'b0;
            if (!mc_we) result_q <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage; expected values come from an
// arithmetic model of the load/store rules kept in this file.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_aluop;
  logic [31:0] in_mem_addr;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic [31:0] in_wdata;
  logic        mc_ready;
  logic [31:0] mc_rdata;
  logic        mc_req, mc_we, stall_req, wb_wreg;
  logic [31:0] mc_addr, mc_wdata, wb_wdata;
  logic [1:0]  mc_len;
  logic [4:0]  wb_wd;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.ADDR_W(32), .DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .in_aluop(in_aluop), .in_mem_addr(in_mem_addr),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .mc_ready(mc_ready), .mc_rdata(mc_rdata), .mc_req(mc_req), .mc_we(mc_we),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_len(mc_len),
    .stall_req(stall_req), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_mem_op(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd8);
  endfunction

  function automatic bit is_store_op(input logic [3:0] op);
    return (op >= 4'd6 && op <= 4'd8);
  endfunction

  function automatic logic [1:0] exp_len(input logic [3:0] op);
    int bytes;
    case (op)
      4'd1, 4'd4, 4'd6: bytes = 1;
      4'd2, 4'd5, 4'd7: bytes = 2;
      default:          bytes = 4;
    endcase
    return 2'(bytes - 1);
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] rd);
    longint v;
    case (op)
      4'd1: begin v = rd % 256;   if (v >= 128)   v = v - 256;   end
      4'd2: begin v = rd % 65536; if (v >= 32768) v = v - 65536; end
      4'd4: v = rd % 256;
      4'd5: v = rd % 65536;
      default: v = rd;
    endcase
    return 32'(v);
  endfunction

  // Request spacing: at least two low cycles between consecutive requests.
  int   low_cnt  = 100;
  bit   seen_req = 1'b0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (mc_req === 1'b1 && req_prev !== 1'b1) begin
      if (seen_req) check("req_gap", 32'(low_cnt >= 2), 32'd1);
      seen_req = 1'b1;
    end
    low_cnt  = (mc_req === 1'b1) ? 0 : low_cnt + 1;
    req_prev = mc_req;
  end

  // Presents one opcode and drives the controller with ready after wt+1 BUSY cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                        input int wt);
    int stalls = 0;
    bit st;
    st = is_store_op(op);
    in_aluop = op; in_mem_addr = addr; in_wdata = wdata; in_wd = wd; in_wreg = wreg;
    mc_ready = 1'b0;
    #1;
    if (!is_mem_op(op)) begin
      check("nop_stall", 32'(stall_req), 32'd0);
      check("nop_req", 32'(mc_req), 32'd0);
      check("nop_wd", 32'(wb_wd), 32'(wd));
      check("nop_wreg", 32'(wb_wreg), 32'(wreg));
      check("nop_wdata", wb_wdata, wdata);
      step();
      return;
    end
    check("idle_stall", 32'(stall_req), 32'd1);
    check("idle_wreg", 32'(wb_wreg), 32'd0);
    check("idle_req", 32'(mc_req), 32'd0);
    stalls += int'(stall_req);
    step();
    for (int i = 0; i <= wt; i++) begin
      check("busy_req", 32'(mc_req), 32'd1);
      check("busy_we", 32'(mc_we), 32'(st));
      check("busy_addr", mc_addr, addr);
      check("busy_wdata", mc_wdata, wdata);
      check("busy_len", 32'(mc_len), 32'(exp_len(op)));
      check("busy_wreg", 32'(wb_wreg), 32'd0);
      stalls += int'(stall_req);
      mc_ready = (i == wt);
      mc_rdata = (i == wt) ? rdata : $urandom;
      step();
    end
    mc_ready = 1'b0;
    mc_rdata = $urandom;
    #1;
    check("stall_cycles", 32'(stalls), 32'(wt + 2));
    check("done_stall", 32'(stall_req), 32'd0);
    check("done_req", 32'(mc_req), 32'd0);
    check("done_wd", 32'(wb_wd), 32'(wd));
    check("done_wreg", 32'(wb_wreg), st ? 32'd0 : 32'(wreg));
    check("done_wdata", wb_wdata, st ? wdata : exp_load(op, rdata));
    step();
  endtask

  initial begin
    rst = 1'b1; in_aluop = 4'd0; in_mem_addr = '0; in_wd = '0; in_wreg = 1'b0;
    in_wdata = '0; mc_ready = 1'b0; mc_rdata = '0;
    step(); step();
    check("rst_req", 32'(mc_req), 32'd0);
    check("rst_we", 32'(mc_we), 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    check("rst_wdata", mc_wdata, 32'd0);
    check("rst_len", 32'(mc_len), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    rst = 1'b0;

    run_op(4'd0, 32'h0, 32'h1234, 32'h0, 5'd5, 1'b1, 0);
    run_op(4'd1, 32'h100, 32'h0, 32'h0000_0080, 5'd7, 1'b1, 1);
    run_op(4'd4, 32'h100, 32'h0, 32'h0000_0080, 5'd8, 1'b1, 1);
    run_op(4'd2, 32'h104, 32'h0, 32'h0000_F00D, 5'd9, 1'b1, 1);
    run_op(4'd5, 32'h106, 32'h0, 32'h0000_F00D, 5'd10, 1'b1, 2);
    run_op(4'd3, 32'h108, 32'h0, 32'hDEAD_BEEF, 5'd11, 1'b1, 0);
    run_op(4'd8, 32'h2000, 32'hCAFE_BABE, 32'h1111_1111, 5'd12, 1'b1, 2);
    run_op(4'd6, 32'h2001, 32'hCAFE_BABE, 32'h0, 5'd13, 1'b1, 1);
    run_op(4'd7, 32'h2002, 32'hCAFE_BABE, 32'h0, 5'd14, 1'b1, 0);
    run_op(4'd9, 32'h3000, 32'h5555_AAAA, 32'h0, 5'd15, 1'b1, 0);
    run_op(4'd15, 32'h3000, 32'hA5A5_5A5A, 32'h0, 5'd16, 1'b0, 0);

    // Spurious ready in IDLE with NOP.
    in_aluop = 4'd0; in_wdata = 32'h7777_0001; in_wd = 5'd3; in_wreg = 1'b1;
    mc_ready = 1'b1; mc_rdata = 32'hFFFF_FFFF;
    step();
    mc_ready = 1'b0;
    #1;
    check("spur_req", 32'(mc_req), 32'd0);
    check("spur_stall", 32'(stall_req), 32'd0);
    check("spur_wdata", wb_wdata, 32'h7777_0001);

    // Back-to-back LW then SW.
    run_op(4'd3, 32'h40, 32'h0, 32'h0BAD_F00D, 5'd1, 1'b1, 0);
    run_op(4'd8, 32'h44, 32'h1357_9BDF, 32'h0, 5'd2, 1'b1, 0);

    // Reset during BUSY.
    in_aluop = 4'd3; in_mem_addr = 32'h500; in_wdata = 32'h0; in_wd = 5'd4; in_wreg = 1'b1;
    #1;
    step();
    check("mid_busy_req", 32'(mc_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_aluop = 4'd0; in_wdata = 32'h0000_BEEF; in_wd = 5'd6;
    #1;
    check("mid_rst_req", 32'(mc_req), 32'd0);
    check("mid_rst_stall", 32'(stall_req), 32'd0);
    check("mid_rst_addr", mc_addr, 32'd0);
    mc_ready = 1'b1; mc_rdata = 32'h1234_5678;
    step();
    mc_ready = 1'b0;
    #1;
    check("late_rdy_req", 32'(mc_req), 32'd0);
    check("late_rdy_stall", 32'(stall_req), 32'd0);
    check("late_rdy_wdata", wb_wdata, 32'h0000_BEEF);
    check("late_rdy_wreg", 32'(wb_wreg), 32'd1);

    for (int k = 0; k < 40; k++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
